// File: rtl/wb_if_pkg.sv
// ============================================================================
// wb_if_pkg : shared state encoding and default sizing for wb_if_master
// Revision  : 1.0
// ============================================================================
`default_nettype none

package wb_if_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 2;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACK_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/wb_if_master.sv
// ============================================================================
// wb_if_master : single-transfer Wishbone master with ack timeout and monitor
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wb_if_master
  import wb_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  mon_valid_o,
  output logic [ADDR_WIDTH-1:0] mon_adr_o,
  output logic [DATA_WIDTH-1:0] mon_dat_o,
  output logic                  mon_we_o
);

  localparam int               c_CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_ONE  = c_CNT_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [c_CNT_W-1:0]    r_wait;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic                  r_rsp_err;
  logic                  r_mon_valid;
  logic [ADDR_WIDTH-1:0] r_mon_adr;
  logic [DATA_WIDTH-1:0] r_mon_dat;
  logic                  r_mon_we;

  logic                  w_in_bus;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_done_dat;

  assign w_in_bus   = (r_state == ST_BUS);
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_ack      = w_in_bus && ack_i;
  // An ack arriving on the final wait cycle still wins over the timeout.
  assign w_timeout  = w_in_bus && !ack_i && (r_wait == c_WAIT_LAST);
  assign w_done_dat = r_we ? r_dat : dat_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid_i) w_state_nxt = ST_BUS;
      ST_BUS:  if (ack_i || (r_wait == c_WAIT_LAST)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr       <= '0;
      r_we        <= 1'b0;
      r_dat       <= '0;
      r_wait      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_mon_valid <= 1'b0;
      r_mon_adr   <= '0;
      r_mon_dat   <= '0;
      r_mon_we    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_mon_valid <= 1'b0;
      if (w_accept) begin
        r_adr  <= cmd_adr_i;
        r_we   <= cmd_we_i;
        // Read data is never driven onto dat_o, so it is not captured at all.
        r_dat  <= cmd_we_i ? cmd_dat_i : '0;
        r_wait <= '0;
      end else if (w_ack) begin
        r_wait      <= '0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_dat   <= w_done_dat;
        r_mon_valid <= 1'b1;
        r_mon_adr   <= r_adr;
        r_mon_dat   <= w_done_dat;
        r_mon_we    <= r_we;
      end else if (w_timeout) begin
        r_wait      <= '0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_dat   <= '0;
      end else if (w_in_bus) begin
        r_wait <= r_wait + c_WAIT_ONE;
      end
    end
  end

  assign cmd_ready_o = !w_in_bus;
  assign cyc_o       = w_in_bus;
  assign stb_o       = w_in_bus;
  assign we_o        = w_in_bus && r_we;
  assign adr_o       = w_in_bus ? r_adr : '0;
  assign dat_o       = w_in_bus ? r_dat : '0;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign mon_valid_o = r_mon_valid;
  assign mon_adr_o   = r_mon_adr;
  assign mon_dat_o   = r_mon_dat;
  assign mon_we_o    = r_mon_we;

endmodule

`default_nettype wire

// File: tb/tb_wb_if_master.sv
// ============================================================================
// tb_wb_if_master : directed bench with response scoreboard for wb_if_master
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_wb_if_master;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_we_i = 1'b0;
  logic [1:0] cmd_adr_i = '0;
  logic [7:0] cmd_dat_i = '0;
  logic       rsp_valid_o;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i = 1'b0;
  logic [7:0] dat_i = 8'hEE;
  logic       mon_valid_o;
  logic [1:0] mon_adr_o;
  logic [7:0] mon_dat_o;
  logic       mon_we_o;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
    logic [1:0] adr;
    logic       we;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_if_master #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .ACK_TIMEOUT(16)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .ack_i      (ack_i),
    .dat_i      (dat_i),
    .mon_valid_o(mon_valid_o),
    .mon_adr_o  (mon_adr_o),
    .mon_dat_o  (mon_dat_o),
    .mon_we_o   (mon_we_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every response is matched against the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_i && mon_valid_o) chk("mon_with_rsp", {31'b0, rsp_valid_o}, 32'd1);
    if (rst_i && rsp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
        chk("rsp_dat", {24'b0, rsp_dat_o}, {24'b0, e.dat});
        if (e.err) begin
          chk("mon_valid_on_err", {31'b0, mon_valid_o}, 32'd0);
        end else begin
          chk("mon_valid", {31'b0, mon_valid_o}, 32'd1);
          chk("mon_adr", {30'b0, mon_adr_o}, {30'b0, e.adr});
          chk("mon_dat", {24'b0, mon_dat_o}, {24'b0, e.dat});
          chk("mon_we", {31'b0, mon_we_o}, {31'b0, e.we});
        end
      end
    end
  end

  task automatic do_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                         input int waits, input logic [7:0] rdata);
    int n;
    exp_t e;
    e.err = 1'b0;
    e.dat = we ? dat : rdata;
    e.adr = adr;
    e.we  = we;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    chk("xfer_ready", {31'b0, cmd_ready_o}, 32'd1);
    sb.push_back(e);
    tick();
    cmd_valid_i = 1'b0;
    chk("xfer_cyc", {31'b0, cyc_o}, 32'd1);
    chk("xfer_stb", {31'b0, stb_o}, 32'd1);
    chk("xfer_we_o", {31'b0, we_o}, {31'b0, we});
    chk("xfer_adr_o", {30'b0, adr_o}, {30'b0, adr});
    chk("xfer_dat_o", {24'b0, dat_o}, we ? {24'b0, dat} : 32'd0);
    n = 1;
    for (int i = 0; i < waits; i++) begin
      tick();
      if (cyc_o) n++;
    end
    ack_i = 1'b1;
    dat_i = rdata;
    tick();
    ack_i = 1'b0;
    dat_i = 8'hEE;
    chk("xfer_cyc_len", n, waits + 1);
    chk("xfer_cyc_drop", {31'b0, cyc_o}, 32'd0);
    chk("xfer_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    tick();
    chk("xfer_rsp_pulse", {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;

    // Reset values
    #3;
    chk("rst_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rst_cyc", {31'b0, cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, stb_o}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_mon_valid", {31'b0, mon_valid_o}, 32'd0);
    chk("rst_outs", {4'b0, adr_o, dat_o, we_o, rsp_dat_o, rsp_err_o, mon_adr_o, mon_dat_o, mon_we_o}, 32'd0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // Write adr 1 / 0x05 with two wait cycles
    do_xfer(1'b1, 2'd1, 8'h05, 2, 8'h99);

    // Read adr 2, zero-wait ack returning 0x86
    do_xfer(1'b0, 2'd2, 8'hAA, 0, 8'h86);
    tick();
    tick();
    chk("hold_rsp_dat", {24'b0, rsp_dat_o}, 32'h86);
    chk("hold_mon_dat", {24'b0, mon_dat_o}, 32'h86);
    chk("hold_mon_we", {31'b0, mon_we_o}, 32'd0);
    chk("hold_mon_adr", {30'b0, mon_adr_o}, 32'd2);

    // Back-to-back writes to adr 1
    e = '{err: 1'b0, dat: 8'h44, adr: 2'd1, we: 1'b1};
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 2'd1; cmd_dat_i = 8'h44;
    tick();
    cmd_valid_i = 1'b0;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("b2b_rsp1", {31'b0, rsp_valid_o}, 32'd1);
    chk("b2b_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("b2b_idle_gap", {31'b0, cyc_o}, 32'd0);
    e = '{err: 1'b0, dat: 8'h78, adr: 2'd1, we: 1'b1};
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_dat_i = 8'h78;
    tick();
    cmd_valid_i = 1'b0;
    chk("b2b_cyc2", {31'b0, cyc_o}, 32'd1);
    chk("b2b_dat_o2", {24'b0, dat_o}, 32'h78);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("b2b_rsp2", {31'b0, rsp_valid_o}, 32'd1);
    chk("b2b_cyc_drop", {31'b0, cyc_o}, 32'd0);
    tick();

    // Ack timeout on a read of adr 3
    e = '{err: 1'b1, dat: 8'h00, adr: 2'd3, we: 1'b0};
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 2'd3; cmd_dat_i = 8'h00;
    tick();
    cmd_valid_i = 1'b0;
    n = cyc_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!cyc_o) break;
      n++;
    end
    chk("to_cyc_len", n, 16);
    chk("to_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("to_rsp_err", {31'b0, rsp_err_o}, 32'd1);
    chk("to_mon_valid", {31'b0, mon_valid_o}, 32'd0);
    chk("to_ready", {31'b0, cmd_ready_o}, 32'd1);
    tick();
    chk("to_mon_hold", {21'b0, mon_adr_o, mon_dat_o, mon_we_o}, {21'b0, 2'd1, 8'h78, 1'b1});

    // Ack while idle must do nothing
    ack_i = 1'b1;
    tick();
    tick();
    ack_i = 1'b0;
    chk("idle_ack_cyc", {31'b0, cyc_o}, 32'd0);
    chk("idle_ack_rsp", {31'b0, rsp_valid_o}, 32'd0);

    // Asynchronous reset in the middle of a write
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 2'd2; cmd_dat_i = 8'h33;
    tick();
    cmd_valid_i = 1'b0;
    chk("abort_cyc_before", {31'b0, cyc_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("abort_cyc", {31'b0, cyc_o}, 32'd0);
    chk("abort_stb", {31'b0, stb_o}, 32'd0);
    chk("abort_ready", {31'b0, cmd_ready_o}, 32'd1);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("abort_no_rsp", {30'b0, rsp_valid_o, mon_valid_o}, 32'd0);
    #2;
    rst_i = 1'b1;
    tick();
    chk("abort_no_rsp_after", {31'b0, rsp_valid_o}, 32'd0);
    do_xfer(1'b0, 2'd1, 8'h00, 1, 8'h5A);

    // Command pulsed during BUS is dropped
    do_xfer_ignore();

    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic do_xfer_ignore();
    exp_t e;
    e = '{err: 1'b0, dat: 8'h11, adr: 2'd0, we: 1'b1};
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 2'd0; cmd_dat_i = 8'h11;
    tick();
    cmd_we_i = 1'b0; cmd_adr_i = 2'd3; cmd_dat_i = 8'hC3;
    chk("busy_ready", {31'b0, cmd_ready_o}, 32'd0);
    tick();
    tick();
    chk("busy_adr_held", {30'b0, adr_o}, 32'd0);
    chk("busy_dat_held", {24'b0, dat_o}, 32'h11);
    cmd_valid_i = 1'b0;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("busy_rsp", {31'b0, rsp_valid_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_no_second", {31'b0, cyc_o}, 32'd0);
    end
  endtask

endmodule

`default_nettype wire

// File: doc/wb_if_master.md
WB_IF_MASTER -- requirements
Module: wb_if_master

Interface
- REQ-001: Parameter ADDR_WIDTH, default 2, Wishbone address width.
- REQ-002: Parameter DATA_WIDTH, default 8, Wishbone data width.
- REQ-003: Parameter ACK_TIMEOUT, default 16, maximum cycles stb_o may wait for ack_i.
- REQ-004: clk_i  in  1  sole clock; all logic on rising edge.
- REQ-005: rst_i  in  1  reset, asynchronous, active-low.
- REQ-006: cmd_valid_i  in  1  transfer request.
- REQ-007: cmd_ready_o  out  1  request accepted when high together with cmd_valid_i.
- REQ-008: cmd_we_i  in  1  1 = write, 0 = read.
- REQ-009: cmd_adr_i  in  ADDR_WIDTH  transfer address.
- REQ-010: cmd_dat_i  in  DATA_WIDTH  write data.
- REQ-011: rsp_valid_o  out  1  one-cycle pulse, transfer finished.
- REQ-012: rsp_dat_o  out  DATA_WIDTH  read data (reads) or echoed write data (writes).
- REQ-013: rsp_err_o  out  1  qualifies rsp_valid_o; 1 = ack timeout.
- REQ-014: cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
- REQ-015: adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH  Wishbone address and write data.
- REQ-016: ack_i  in  1; dat_i  in  DATA_WIDTH  Wishbone slave acknowledge and read data.
- REQ-017: mon_valid_o  out  1; mon_adr_o  out  ADDR_WIDTH; mon_dat_o  out  DATA_WIDTH; mon_we_o  out  1  record of each successfully acknowledged transfer.

Function
- REQ-018: The FSM SHALL have states IDLE and BUS; cmd_ready_o = 1 only in IDLE.
- REQ-019: On a posedge with cmd_valid_i & cmd_ready_o, the block SHALL register adr/we/dat, enter BUS, and assert cyc_o = stb_o = 1 from that edge onward.
- REQ-020: In BUS, adr_o, we_o and dat_o SHALL hold the registered values; dat_o SHALL be 0 on reads and in IDLE; adr_o and we_o SHALL be 0 in IDLE.
- REQ-021: When ack_i = 1 is sampled in BUS, the block SHALL drop cyc_o/stb_o on that edge, return to IDLE and pulse rsp_valid_o with rsp_err_o = 0 for exactly one cycle.
- REQ-022: On reads rsp_dat_o SHALL equal dat_i sampled on the ack edge; on writes it SHALL equal the written data; the value SHALL hold until the next response.
- REQ-023: mon_valid_o SHALL pulse concurrently with every error-free rsp_valid_o, with mon_adr_o/mon_dat_o/mon_we_o = address, rsp_dat_o value and direction; mon_* SHALL hold between pulses.
- REQ-024: ack_i sampled in IDLE SHALL be ignored.
- REQ-025: A wait counter SHALL count BUS cycles without ack; after ACK_TIMEOUT cycles the block SHALL drop cyc_o/stb_o, return to IDLE and pulse rsp_valid_o with rsp_err_o = 1, rsp_dat_o = 0, with no mon_valid_o.
- REQ-026: Minimum transfer SHALL be 2 cycles (accept edge, ack edge); a new command SHALL be acceptable in the same cycle as rsp_valid_o (back-to-back, one idle cycle on cyc_o between transfers).
- REQ-027: cmd_valid_i while in BUS SHALL be ignored (not queued).

Reset
- REQ-028: While rst_i = 0, all outputs SHALL be 0 except cmd_ready_o = 1; the FSM SHALL be in IDLE and the counter 0.
- REQ-029: Reset asserted mid-transfer SHALL immediately (asynchronously) drop cyc_o/stb_o, with no rsp_valid_o or mon_valid_o for the aborted transfer.

Structure
- REQ-030: The shared package wb_if_pkg SHALL hold the state enumeration (IDLE, BUS) and the default width and timeout constants.
- REQ-031: The block SHALL be a single module with no sub-modules.

Verification
- REQ-032: Write adr 1, data 0x05, ack after 2 wait cycles -> cyc_o/stb_o high 3 cycles, we_o = 1, dat_o = 0x05, rsp_valid_o and mon_valid_o pulse (adr 1, 0x05, we 1).
- REQ-033: Read adr 2, slave returns 0x86 with zero-wait ack -> rsp_dat_o = 0x86, mon_dat_o = 0x86, mon_we_o = 0, dat_o = 0.
- REQ-034: Back-to-back writes 0x44 then 0x78 to adr 1 -> two responses in order, exactly one idle cycle on cyc_o between them.
- REQ-035: No ack for ACK_TIMEOUT = 16 cycles -> cyc_o drops after cycle 16, rsp_err_o = 1, no mon_valid_o, cmd_ready_o = 1.
- REQ-036: rst_i = 0 while in BUS -> cyc_o/stb_o drop immediately, no response; a read accepted after release completes normally.
- REQ-037: cmd_valid_i pulsed while in BUS, then ack -> only the first transfer completes.
